// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module      : uart_tx_fifo
// Description : UART transmitter with an input FIFO. Data width, parity and
//               stop bits are set by parameters. Queued frames are sent
//               back-to-back with no idle gap between them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Tx_DV,
  input  logic [DATA_BITS-1:0]          i_Tx_Byte,
  output logic                          o_Tx_Ready,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Done,
  output logic                          o_Overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [BAUD_W-1:0] C_BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  C_LAST_DATA   = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  C_LAST_STOP   = BIT_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0]  C_FULL        = CNT_W'(FIFO_DEPTH);

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_tx_fifo: illegal parameter value");
  end

  // ---------------------------------------------------------------- FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count, count_n;
  logic                 ready, overflow;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  assign push = i_Tx_DV & ready;
  assign head = mem[rd_ptr];

  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + CNT_W'(1);
      2'b01:   count_n = count - CNT_W'(1);
      default: count_n = count;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count    <= count_n;
      ready    <= (count_n != C_FULL);
      overflow <= i_Tx_DV & ~ready;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (push) mem[wr_ptr] <= i_Tx_Byte;
  end

  // ---------------------------------------------------------------- FSM
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [BAUD_W-1:0]    baud, baud_n;
  logic [BIT_W-1:0]     bit_idx, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_bit, par_n;
  logic                 serial, serial_n;
  logic                 active, active_n;
  logic                 done, done_n;
  logic                 load;
  logic                 baud_end;

  always_comb begin
    state_n  = state;
    baud_n   = baud;
    bit_n    = bit_idx;
    shreg_n  = shreg;
    par_n    = par_bit;
    serial_n = serial;
    done_n   = 1'b0;
    load     = 1'b0;
    pop      = 1'b0;
    baud_end = (baud == '0);

    case (state)
      S_IDLE: begin
        serial_n = 1'b1;
        if (count != '0) load = 1'b1;
      end
      S_START: begin
        if (baud_end) begin
          state_n  = S_DATA;
          baud_n   = C_BAUD_RELOAD;
          bit_n    = '0;
          serial_n = shreg[0];
        end else begin
          baud_n = baud - BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_n = C_BAUD_RELOAD;
          if (bit_idx == C_LAST_DATA) begin
            bit_n = '0;
            if (PARITY != 0) begin
              state_n  = S_PARITY;
              serial_n = par_bit;
            end else begin
              state_n  = S_STOP;
              serial_n = 1'b1;
            end
          end else begin
            // shreg[0] is always the bit currently on the line
            bit_n    = bit_idx + BIT_W'(1);
            shreg_n  = shreg >> 1;
            serial_n = shreg[1];
          end
        end else begin
          baud_n = baud - BAUD_W'(1);
        end
      end
      S_PARITY: begin
        if (baud_end) begin
          state_n  = S_STOP;
          baud_n   = C_BAUD_RELOAD;
          bit_n    = '0;
          serial_n = 1'b1;
        end else begin
          baud_n = baud - BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_n = C_BAUD_RELOAD;
          if (bit_idx == C_LAST_STOP) begin
            done_n = 1'b1;
            if (count != '0) begin
              load = 1'b1;
            end else begin
              state_n  = S_IDLE;
              serial_n = 1'b1;
            end
          end else begin
            bit_n = bit_idx + BIT_W'(1);
          end
        end else begin
          baud_n = baud - BAUD_W'(1);
        end
      end
      default: begin
        state_n  = S_IDLE;
        serial_n = 1'b1;
      end
    endcase

    // Pop the head straight into the shifter; parity is fixed at load time
    if (load) begin
      pop      = 1'b1;
      shreg_n  = head;
      par_n    = (^head) ^ (PARITY == 1);
      state_n  = S_START;
      baud_n   = C_BAUD_RELOAD;
      serial_n = 1'b0;
    end

    active_n = (state_n != S_IDLE);
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      serial  <= 1'b1;
      active  <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      shreg   <= shreg_n;
      par_bit <= par_n;
      serial  <= serial_n;
      active  <= active_n;
      done    <= done_n;
    end
  end

  assign o_Tx_Ready   = ready;
  assign o_Tx_Active  = active;
  assign o_Tx_Serial  = serial;
  assign o_Tx_Done    = done;
  assign o_Overflow   = overflow;
  assign o_Fifo_Count = count;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Directed bench for uart_tx_fifo with a frame scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

  localparam int CPB = 87;
  // instance 0: 8N1, 1: 8E1, 2: 8O1, 3: 7N2
  localparam int PAR_T [4] = '{0, 2, 1, 0};
  localparam int DB_T  [4] = '{8, 8, 8, 7};
  localparam int SB_T  [4] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] dv  = '0;
  logic [8:0] din = '0;
  logic [3:0] rdy, act, ser, done, ovf;
  logic [2:0] cnt [4];

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [15:0] bits;
    int          len;
  } frame_t;
  frame_t sb[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_fifo #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (DB_T[g]),
      .PARITY      (PAR_T[g]),
      .STOP_BITS   (SB_T[g]),
      .FIFO_DEPTH  (4)
    ) dut (
      .i_Clock     (clk),
      .i_Reset     (rst),
      .i_Tx_DV     (dv[g]),
      .i_Tx_Byte   (din[DB_T[g]-1:0]),
      .o_Tx_Ready  (rdy[g]),
      .o_Tx_Active (act[g]),
      .o_Tx_Serial (ser[g]),
      .o_Tx_Done   (done[g]),
      .o_Overflow  (ovf[g]),
      .o_Fifo_Count(cnt[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s: observed no event, expected event", tag);
  endtask

  function automatic frame_t mk(input int k, input logic [8:0] d);
    frame_t f;
    int     n;
    logic   p;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    n = 1;
    p = 1'b0;
    for (int i = 0; i < DB_T[k]; i++) begin
      f.bits[n] = d[i];
      p = p ^ d[i];
      n++;
    end
    if (PAR_T[k] == 2) begin
      f.bits[n] = p;
      n++;
    end else if (PAR_T[k] == 1) begin
      f.bits[n] = ~p;
      n++;
    end
    f.len = n + SB_T[k];
    return f;
  endfunction

  // Called at a negedge; holds the strobe across exactly one rising edge
  task automatic put(input int k, input logic [8:0] d, input bit expect_tx);
    dv[k] = 1'b1;
    din   = d;
    if (expect_tx) sb.push_back(mk(k, d));
    @(negedge clk);
    dv[k] = 1'b0;
  endtask

  // pre = cycles already elapsed since the start-bit edge when called
  task automatic recv(input int k, input int pre, output int lat, output logic act_end);
    frame_t      f;
    logic [15:0] got;
    int          n;
    got     = '1;
    n       = 0;
    lat     = -1;
    act_end = 1'bx;
    while (ser[k] !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() == 0) begin
      fail("scoreboard_empty");
      return;
    end
    f = sb.pop_front();
    if (ser[k] !== 1'b0) begin
      fail("start_bit_timeout");
      return;
    end
    lat = n;
    repeat (43 - pre) @(negedge clk);
    for (int b = 0; b < f.len; b++) begin
      got[b] = ser[k];
      if (b != f.len - 1) repeat (CPB) @(negedge clk);
    end
    chk("frame_bits", got, f.bits);
    repeat (43) @(negedge clk);
    chk("done_early", done[k], 1'b0);
    @(negedge clk);
    chk("done_pulse", done[k], 1'b1);
    act_end = act[k];
  endtask

  initial begin
    int   lat;
    logic a;

    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("rst_serial", ser[k], 1'b1);
      chk("rst_active", act[k], 1'b0);
      chk("rst_done",   done[k], 1'b0);
      chk("rst_ovf",    ovf[k], 1'b0);
      chk("rst_count",  cnt[k], 3'd0);
      chk("rst_ready",  rdy[k], 1'b1);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single 8N1 frame from idle
    put(0, 9'h063, 1'b1);
    recv(0, 0, lat, a);
    chk("t1_latency", lat, 32'd1);
    chk("t1_active_end", a, 1'b0);

    // two frames back-to-back
    repeat (5) @(negedge clk);
    put(0, 9'h063, 1'b1);
    put(0, 9'h031, 1'b1);
    recv(0, 0, lat, a);
    chk("t2_lat0", lat, 32'd0);
    chk("t2_active_mid", a, 1'b1);
    recv(0, 0, lat, a);
    chk("t2_lat1", lat, 32'd0);
    chk("t2_active_end", a, 1'b0);

    // even and odd parity
    repeat (3) @(negedge clk);
    put(1, 9'h031, 1'b1);
    recv(1, 0, lat, a);
    chk("t3_even_lat", lat, 32'd1);
    put(2, 9'h031, 1'b1);
    recv(2, 0, lat, a);
    chk("t3_odd_lat", lat, 32'd1);

    // 7 data bits, 2 stop bits
    put(3, 9'h055, 1'b1);
    recv(3, 0, lat, a);
    chk("t4_lat", lat, 32'd1);
    chk("t4_active_end", a, 1'b0);

    // overflow: six consecutive writes, the sixth dropped
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) put(0, 9'(9'h0A0 + i), i < 5);
    chk("t5_ovf_pulse", ovf[0], 1'b1);
    chk("t5_ready_full", rdy[0], 1'b0);
    chk("t5_count_full", cnt[0], 3'd4);
    @(negedge clk);
    chk("t5_ovf_single", ovf[0], 1'b0);
    recv(0, 5, lat, a);
    chk("t5_active_0", a, 1'b1);
    for (int i = 1; i < 5; i++) begin
      recv(0, 0, lat, a);
      chk("t5_lat", lat, 32'd0);
    end
    chk("t5_active_end", a, 1'b0);

    // reset in the middle of a queued stream
    repeat (3) @(negedge clk);
    put(0, 9'h0F0, 1'b0);
    put(0, 9'h00F, 1'b0);
    put(0, 9'h0AA, 1'b0);
    repeat (300) @(negedge clk);
    chk("t6_active_before", act[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t6_serial_rst", ser[0], 1'b1);
    chk("t6_active_rst", act[0], 1'b0);
    chk("t6_count_rst",  cnt[0], 3'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_done", done[0], 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("t6_no_done_after", done[0], 1'b0);
    put(0, 9'h0A5, 1'b1);
    recv(0, 0, lat, a);
    chk("t6_lat", lat, 32'd1);

    chk("sb_leftover", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
